lms_adapt_ctrl: RTL and testbench

//  Sequences adaptation of the FIR/LMS equalizer: coefficient clear, training with known symbols, then

---
 rtl/lms_adapt_ctrl_pkg.sv | 22 ++
 rtl/lms_adapt_ctrl_err_win_acc.sv | 66 ++++++
 rtl/lms_adapt_ctrl.sv | 149 ++++++++++++++
 tb/tb_lms_adapt_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_adapt_ctrl_pkg.sv
// Shared definitions for the LMS adaptation controller: state codes and step-size width.
package lms_adapt_ctrl_pkg;

    localparam int unsigned MuShW = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StTrain = 3'd2,
        StDd    = 3'd3,
        StFail  = 3'd4
    } state_e;

    function automatic logic is_busy(state_e s);
        return (s == StClear) || (s == StTrain) || (s == StDd);
    endfunction

    function automatic logic is_adapting(state_e s);
        return (s == StTrain) || (s == StDd);
    endfunction

endpackage

// File: rtl/lms_adapt_ctrl_err_win_acc.sv
// Windowed |err| accumulator: saturating sum of |err| over 2**WIN_LOG2 enabled samples,
// with an end-of-window strobe and the final window sum (including the current sample).
module lms_adapt_ctrl_err_win_acc #(
    parameter int unsigned NBerr    = 8,
    parameter int unsigned NBacc    = 16,
    parameter int unsigned WIN_LOG2 = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [NBerr-1:0] err_i,
    output logic             win_end_o,
    output logic [NBacc-1:0] win_sum_o
);

    logic [NBacc-1:0]    acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [NBerr-1:0]    neg_err;
    logic [NBerr-2:0]    abs_err;
    logic [NBacc:0]      sum_wide;

    // The most negative code has no positive twin; clamp its magnitude to the largest positive.
    always_comb begin
        neg_err = (~err_i) + NBerr'(1);
        if (err_i == {1'b1, {(NBerr-1){1'b0}}}) begin
            abs_err = '1;
        end else if (err_i[NBerr-1]) begin
            abs_err = neg_err[NBerr-2:0];
        end else begin
            abs_err = err_i[NBerr-2:0];
        end
    end

    assign sum_wide  = {1'b0, acc_q} + {{(NBacc+2-NBerr){1'b0}}, abs_err};
    assign win_sum_o = sum_wide[NBacc] ? '1 : sum_wide[NBacc-1:0];
    assign win_end_o = en_i && (cnt_q == '1);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == '1) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = win_sum_o;
                cnt_d = cnt_q + WIN_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lms_adapt_ctrl.sv
// LMS adaptation sequencer: clear, training, then decision-directed tracking with gear-shift mu.
// Optional macro LMS_FREEZE_EN adds a freeze input that pauses adaptation in TRAIN/DD.
module lms_adapt_ctrl
    import lms_adapt_ctrl_pkg::*;
#(
    parameter int unsigned NBerr     = 8,
    parameter int unsigned NBacc     = 16,
    parameter int unsigned WIN_LOG2  = 6,
    parameter int unsigned TRAIN_LEN = 256,
    parameter int unsigned MU_SH_INI = 2,
    parameter int unsigned MU_SH_MAX = 7,
    parameter int unsigned CONV_THR  = 64,
    parameter int unsigned DIV_THR   = 4000
) (
    input  logic             clkA,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             valid_in,
    input  logic [NBerr-1:0] err,
`ifdef LMS_FREEZE_EN
    input  logic             freeze,
`endif
    output logic             lms_en,
    output logic             train_sel,
    output logic [3:0]       mu_shift,
    output logic             coeff_clr,
    output logic             busy,
    output logic             converged,
    output logic             diverged,
    output logic [2:0]       state_o
);

    localparam int unsigned TrainW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;

    state_e             state_q, state_d;
    logic [MuShW-1:0]   mu_q, mu_d;
    logic               conv_q, conv_d;
    logic               div_q, div_d;
    logic [TrainW-1:0]  train_cnt_q, train_cnt_d;
    logic               coeff_clr_q, train_sel_q, busy_q;
    logic               adv;
    logic               win_end;
    logic [NBacc-1:0]   win_sum;

`ifdef LMS_FREEZE_EN
    assign adv = valid_in & ~freeze;
`else
    assign adv = valid_in;
`endif

    assign lms_en = adv & is_adapting(state_q);

    lms_adapt_ctrl_err_win_acc #(
        .NBerr    (NBerr),
        .NBacc    (NBacc),
        .WIN_LOG2 (WIN_LOG2)
    ) u_err_win_acc (
        .clk_i     (clkA),
        .rst_ni    (reset),
        .clr_i     (state_q != StDd),
        .en_i      (lms_en && (state_q == StDd)),
        .err_i     (err),
        .win_end_o (win_end),
        .win_sum_o (win_sum)
    );

    always_comb begin
        state_d     = state_q;
        mu_d        = mu_q;
        conv_d      = conv_q;
        div_d       = div_q;
        train_cnt_d = (state_q == StTrain) ? train_cnt_q : '0;
        // abort wins over start and every other transition; mu_shift is deliberately kept
        if (abort) begin
            state_d = StIdle;
            conv_d  = 1'b0;
            div_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle, StFail: begin
                    if (start) begin
                        state_d = StClear;
                        mu_d    = MuShW'(MU_SH_INI);
                        conv_d  = 1'b0;
                        div_d   = 1'b0;
                    end
                end
                StClear: state_d = StTrain;
                StTrain: begin
                    if (lms_en) begin
                        if (train_cnt_q == TrainW'(TRAIN_LEN - 1)) begin
                            train_cnt_d = '0;
                            state_d     = StDd;
                        end else begin
                            train_cnt_d = train_cnt_q + TrainW'(1);
                        end
                    end
                end
                StDd: begin
                    if (win_end) begin
                        if (32'(win_sum) > DIV_THR) begin
                            div_d   = 1'b1;
                            state_d = StFail;
                        end else if (32'(win_sum) < CONV_THR) begin
                            if (mu_q < MuShW'(MU_SH_MAX)) begin
                                mu_d = mu_q + MuShW'(1);
                            end else begin
                                conv_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mu_q        <= MuShW'(MU_SH_INI);
            conv_q      <= 1'b0;
            div_q       <= 1'b0;
            train_cnt_q <= '0;
            coeff_clr_q <= 1'b0;
            train_sel_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mu_q        <= mu_d;
            conv_q      <= conv_d;
            div_q       <= div_d;
            train_cnt_q <= train_cnt_d;
            coeff_clr_q <= (state_d == StClear);
            train_sel_q <= (state_d == StTrain);
            busy_q      <= is_busy(state_d);
        end
    end

    assign mu_shift  = mu_q;
    assign converged = conv_q;
    assign diverged  = div_q;
    assign coeff_clr = coeff_clr_q;
    assign train_sel = train_sel_q;
    assign busy      = busy_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Self-checking bench for lms_adapt_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the adaptation sequence.
module tb_lms_adapt_ctrl;

    localparam int TrainLen = 256;
    localparam int WinLen   = 64;
    localparam int MuIni    = 2;
    localparam int MuMax    = 7;
    localparam int ConvThr  = 64;
    localparam int DivThr   = 4000;
    localparam int AccMax   = 65535;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       valid = 1'b0;
    logic       freeze = 1'b0;
    logic [7:0] err = 8'd0;

    logic       lms_en, train_sel, coeff_clr, busy, converged, diverged;
    logic [3:0] mu_shift;
    logic [2:0] state_o;

    lms_adapt_ctrl dut (
        .clkA      (clk),
        .reset     (rst_n),
        .start     (start),
        .abort     (abort),
        .valid_in  (valid),
        .err       (err),
`ifdef LMS_FREEZE_EN
        .freeze    (freeze),
`endif
        .lms_en    (lms_en),
        .train_sel (train_sel),
        .mu_shift  (mu_shift),
        .coeff_clr (coeff_clr),
        .busy      (busy),
        .converged (converged),
        .diverged  (diverged),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 idle, 1 clear, 2 train, 3 dd, 4 fail
    int m_state, m_mu, m_conv, m_div, m_tcnt, m_wcnt, m_wsum;
    int n_clr_pulses, n_train_en, n_freeze_en;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_mu = MuIni; m_conv = 0; m_div = 0;
        m_tcnt = 0; m_wcnt = 0; m_wsum = 0;
    endtask

    function automatic int abs_err(input logic [7:0] e);
        int v;
        v = int'($signed(e));
        if (v < 0) v = -v;
        return (v > 127) ? 127 : v;
    endfunction

    function automatic int model_lms();
        return (valid && !freeze && (m_state == 2 || m_state == 3)) ? 1 : 0;
    endfunction

    task automatic model_next();
        int en;
        en = model_lms();
        if (abort) begin
            m_state = 0; m_conv = 0; m_div = 0; m_tcnt = 0; m_wcnt = 0; m_wsum = 0;
        end else if ((m_state == 0 || m_state == 4) && start) begin
            m_state = 1; m_mu = MuIni; m_conv = 0; m_div = 0;
        end else if (m_state == 1) begin
            m_state = 2; m_tcnt = 0;
        end else if (m_state == 2 && en == 1) begin
            m_tcnt++;
            if (m_tcnt == TrainLen) begin
                m_state = 3; m_tcnt = 0; m_wcnt = 0; m_wsum = 0;
            end
        end else if (m_state == 3 && en == 1) begin
            m_wsum = m_wsum + abs_err(err);
            if (m_wsum > AccMax) m_wsum = AccMax;
            m_wcnt++;
            if (m_wcnt == WinLen) begin
                if (m_wsum > DivThr) begin
                    m_div = 1; m_state = 4;
                end else if (m_wsum < ConvThr) begin
                    if (m_mu < MuMax) m_mu++;
                    else m_conv = 1;
                end
                m_wcnt = 0; m_wsum = 0;
            end
        end
    endtask

    task automatic check_regs();
        check_eq("state_o", int'(state_o), m_state);
        check_eq("mu_shift", int'(mu_shift), m_mu);
        check_eq("converged", int'(converged), m_conv);
        check_eq("diverged", int'(diverged), m_div);
        check_eq("coeff_clr", int'(coeff_clr), (m_state == 1) ? 1 : 0);
        check_eq("train_sel", int'(train_sel), (m_state == 2) ? 1 : 0);
        check_eq("busy", int'(busy), (m_state >= 1 && m_state <= 3) ? 1 : 0);
    endtask

    // One clock: check combinational lms_en mid-cycle, advance model, check registers after edge.
    task automatic step();
        @(negedge clk);
        check_eq("lms_en", int'(lms_en), model_lms());
        if (coeff_clr) n_clr_pulses++;
        if (lms_en && state_o == 3'd2) n_train_en++;
        if (freeze && lms_en) n_freeze_en++;
        model_next();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic run_until_state(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (m_state != target && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, int'(state_o), target);
    endtask

    task automatic set_rand_err(input int amp);
        int e;
        if (amp >= 127 && $urandom_range(0, 9) == 0) e = -128;
        else e = int'($urandom_range(0, 2 * amp)) - amp;
        err = 8'(e);
    endtask

    initial begin
        int amp;
        model_reset();
        n_clr_pulses = 0; n_train_en = 0; n_freeze_en = 0;
        repeat (3) @(posedge clk);
        #1;
        check_regs();
        check_eq("reset_lms_en", int'(lms_en), 0);
        rst_n = 1'b1;

        // Quiet line: full clear/train/gear-shift/converge sequence
        start = 1'b1; valid = 1'b1; err = 8'd0;
        step();
        start = 1'b0;
        repeat (700) step();
        check_eq("quiet_clr_pulses", n_clr_pulses, 1);
        check_eq("quiet_train_en", n_train_en, TrainLen);
        check_eq("quiet_converged", int'(converged), 1);
        check_eq("quiet_mu", int'(mu_shift), MuMax);
        abort = 1'b1; step(); abort = 1'b0;

        // Gappy training with small noise, then large constant error -> divergence
        start = 1'b1; step(); start = 1'b0;
        while (m_state != 3 && n_checks < 200000) begin
            valid = ($urandom_range(0, 3) != 0);
            set_rand_err(2);
            step();
        end
        check_eq("gap_reach_dd", int'(state_o), 3);
        valid = 1'b1; err = 8'd100;
        run_until_state(4, 80, "err100_fail");
        check_eq("err100_div", int'(diverged), 1);
        check_eq("err100_lms_off", int'(lms_en), 0);

        // Restart from FAIL, most-negative error in DD
        err = 8'd0; start = 1'b1; step(); start = 1'b0;
        run_until_state(3, 300, "neg_reach_dd");
        err = 8'h80;
        run_until_state(4, 70, "neg128_fail");
        check_eq("neg128_div", int'(diverged), 1);

        // abort+start together in TRAIN, then start alone in TRAIN
        err = 8'd0; start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        n_clr_pulses = 0;
        abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
        check_eq("abort_start_state", int'(state_o), 0);
        start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        start = 1'b1; step(); start = 1'b0;
        check_eq("start_in_train", int'(state_o), 2);
        step();
        check_eq("clr_pulses_abort", n_clr_pulses, 1);

`ifdef LMS_FREEZE_EN
        run_until_state(3, 300, "frz_reach_dd");
        repeat (10) step();
        freeze = 1'b1;
        repeat (20) step();
        freeze = 1'b0;
        check_eq("freeze_lms_en", n_freeze_en, 0);
        repeat (100) step();
`endif

        // Randomized traffic with varying error amplitude
        amp = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: amp = 0;
                    1: amp = 1;
                    2: amp = 40;
                    default: amp = 127;
                endcase
            end
            valid = ($urandom_range(0, 3) != 0);
            set_rand_err(amp);
            start = ($urandom_range(0, 49) == 0);
            abort = ($urandom_range(0, 399) == 0);
`ifdef LMS_FREEZE_EN
            freeze = ($urandom_range(0, 9) == 0);
`endif
            step();
        end
        start = 1'b0; abort = 1'b0; freeze = 1'b0;

        // Asynchronous reset in the middle of DD
        abort = 1'b1; step(); abort = 1'b0;
        valid = 1'b1; err = 8'd0; start = 1'b1; step(); start = 1'b0;
        run_until_state(3, 300, "rst_reach_dd");
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs();
        check_eq("rst_lms_en", int'(lms_en), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        check_eq("rst_idle_after", int'(state_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
